// File: rtl/mem_io_responder.sv
// mem_io_responder
// Memory/I-O responder for a simple CPU: byte-wide RAM with a registered read
// port, plus a small memory-mapped I/O page holding a UART TX FIFO, a 2-entry
// UART RX buffer, a free-running cycle counter with byte snapshot and a sticky
// halt flag.
//
// Ports
//   clk_in          sole clock, rising edge
//   rst_in          synchronous reset, active low
//   mem_a           byte address from CPU (bits 17:0 decoded)
//   mem_wr          1 = write, 0 = read
//   mem_dout        write data from CPU
//   mem_din         read data to CPU, one cycle after the address
//   io_buffer_full  registered TX FIFO nearly-full flag
//   tx_data/valid   TX FIFO head byte / FIFO not empty
//   tx_ready        UART consumes tx_data this cycle
//   rx_data/valid   received UART byte strobe
//   program_end     sticky halt flag
//   tx_overflow     sticky, a TX byte was dropped on a full FIFO
//
// I/O page (mem_a[17:16] == 2'b11, offset = mem_a[15:0])
//   0x0000  W: push nonzero byte to TX   R: pop oldest RX byte (0 if empty)
//   0x0004  W: set program_end           R: snapshot counter, return byte 0
//   0x0005..0x0007  R: bytes 1..3 of the last snapshot
module mem_io_responder #(
   parameter int RAM_ADDR_W  = 17,
   parameter int TX_DEPTH    = 8,
   parameter int FULL_MARGIN = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        program_end,
   output logic        tx_overflow
);

   localparam int PTR_W = $clog2(TX_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(TX_DEPTH);
   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(TX_DEPTH - FULL_MARGIN);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // ------------------------------------------------------------ decode
   logic                  w_is_io;
   logic [15:0]           w_io_off;
   logic [RAM_ADDR_W-1:0] w_ram_idx;
   logic                  w_data_port;
   logic                  w_unused;

   assign w_is_io     = (mem_a[17:16] == 2'b11);
   assign w_io_off    = mem_a[15:0];
   assign w_ram_idx   = mem_a[RAM_ADDR_W-1:0];
   assign w_data_port = w_is_io && (w_io_off == 16'h0000);

   // ------------------------------------------------------------ RAM
   // No reset on the array or its read register so it maps onto block RAM;
   // contents survive reset.
   logic [7:0] r_ram [0:(2**RAM_ADDR_W)-1];
   logic [7:0] r_ram_rdata;

   always_ff @(posedge clk_in) begin
      if (mem_wr && !w_is_io) begin
         r_ram[w_ram_idx] <= mem_dout;
      end
      r_ram_rdata <= r_ram[w_ram_idx];
   end

   // ------------------------------------------------------------ counter
   logic [31:0] r_cycle;
   logic [31:0] r_snap;

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_cycle <= 32'd0;
         r_snap  <= 32'd0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (!mem_wr && w_is_io && (w_io_off == 16'h0004)) begin
            r_snap <= r_cycle;
         end
      end
   end

   // ------------------------------------------------------------ RX buffer
   // r_rx0 is always the oldest byte, r_rx1 the newer one.
   logic [7:0] r_rx0;
   logic [7:0] r_rx1;
   logic [1:0] r_rx_cnt;
   logic       w_rx_pop;

   assign w_rx_pop = !mem_wr && w_data_port && (r_rx_cnt != 2'd0);

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_rx0    <= 8'h00;
         r_rx1    <= 8'h00;
         r_rx_cnt <= 2'd0;
      end else begin
         case ({rx_valid, w_rx_pop})
            2'b01: begin
               r_rx0    <= r_rx1;
               r_rx_cnt <= r_rx_cnt - 2'd1;
            end
            2'b10: begin
               if (r_rx_cnt == 2'd0) begin
                  r_rx0    <= rx_data;
                  r_rx_cnt <= 2'd1;
               end else begin
                  // Second entry, or overwrite of the newest when full.
                  r_rx1    <= rx_data;
                  r_rx_cnt <= 2'd2;
               end
            end
            2'b11: begin
               // The pop frees a slot first, so nothing is overwritten.
               if (r_rx_cnt == 2'd1) begin
                  r_rx0 <= rx_data;
               end else begin
                  r_rx0 <= r_rx1;
                  r_rx1 <= rx_data;
               end
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------ TX FIFO
   logic [7:0]       r_tx_mem [0:TX_DEPTH-1];
   logic [PTR_W-1:0] r_tx_wptr;
   logic [PTR_W-1:0] r_tx_rptr;
   logic [CNT_W-1:0] r_tx_count;
   logic [CNT_W-1:0] w_tx_count_next;
   logic             r_io_full;
   logic             r_program_end;
   logic             r_tx_overflow;
   logic             w_tx_pop;
   logic             w_tx_full;
   logic             w_push_req;
   logic             w_tx_push;
   logic             w_tx_drop;

   assign w_tx_pop   = (r_tx_count != '0) && tx_ready;
   assign w_tx_full  = (r_tx_count == DEPTH_C);
   assign w_push_req = mem_wr && w_data_port && (mem_dout != 8'h00) && !r_program_end;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_tx_push  = w_push_req && (!w_tx_full || w_tx_pop);
   assign w_tx_drop  = w_push_req && w_tx_full && !w_tx_pop;

   always_comb begin
      w_tx_count_next = r_tx_count;
      case ({w_tx_push, w_tx_pop})
         2'b10:   w_tx_count_next = r_tx_count + CNT_ONE;
         2'b01:   w_tx_count_next = r_tx_count - CNT_ONE;
         default: ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (w_tx_push) begin
         r_tx_mem[r_tx_wptr] <= mem_dout;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_tx_wptr     <= '0;
         r_tx_rptr     <= '0;
         r_tx_count    <= '0;
         r_io_full     <= 1'b0;
         r_program_end <= 1'b0;
         r_tx_overflow <= 1'b0;
      end else begin
         if (w_tx_push) begin
            r_tx_wptr <= r_tx_wptr + PTR_ONE;
         end
         if (w_tx_pop) begin
            r_tx_rptr <= r_tx_rptr + PTR_ONE;
         end
         r_tx_count <= w_tx_count_next;
         // Registered from the post-update count: high in the cycle after
         // the push that reaches the threshold.
         r_io_full  <= (w_tx_count_next >= THRESH_C);
         if (w_tx_drop) begin
            r_tx_overflow <= 1'b1;
         end
         if (mem_wr && w_is_io && (w_io_off == 16'h0004)) begin
            r_program_end <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------ read mux
   logic [7:0] w_io_rdata;
   logic [7:0] r_io_rdata;
   logic       r_sel_io;

   always_comb begin
      w_io_rdata = 8'h00;
      if (!mem_wr && w_is_io) begin
         case (w_io_off)
            16'h0000: w_io_rdata = (r_rx_cnt != 2'd0) ? r_rx0 : 8'h00;
            16'h0004: w_io_rdata = r_cycle[7:0];
            16'h0005: w_io_rdata = r_snap[15:8];
            16'h0006: w_io_rdata = r_snap[23:16];
            16'h0007: w_io_rdata = r_snap[31:24];
            default:  w_io_rdata = 8'h00;
         endcase
      end
   end

   // Selecting the I/O path with zero data during reset forces mem_din to 0
   // without touching the RAM read register.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_sel_io   <= 1'b1;
         r_io_rdata <= 8'h00;
      end else begin
         r_sel_io   <= w_is_io;
         r_io_rdata <= w_io_rdata;
      end
   end

   assign mem_din        = r_sel_io ? r_io_rdata : r_ram_rdata;
   assign tx_data        = r_tx_mem[r_tx_rptr];
   assign tx_valid       = (r_tx_count != '0);
   assign io_buffer_full = r_io_full;
   assign program_end    = r_program_end;
   assign tx_overflow    = r_tx_overflow;

   // Address bits above the decoded range and snapshot byte 0 (always read
   // live from the counter) have no function here.
   assign w_unused = ^{mem_a[31:18], r_snap[7:0]};

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter RAM_ADDR_W, default 17, SHALL set the RAM byte-address width (2^17 = 128 KB).
REQ-002 Parameter TX_DEPTH, default 8, SHALL set the UART TX FIFO depth in bytes; it is a power of two and at least 4.
REQ-003 Parameter FULL_MARGIN, default 2, SHALL set how many free TX slots remain when io_buffer_full asserts.
REQ-004 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_in  input  1  reset; synchronous, active-low (0 = reset).
REQ-006 mem_a  input  32  byte address from CPU; only bits 17:0 are decoded.
REQ-007 mem_wr  input  1  1 = write this cycle, 0 = read.
REQ-008 mem_dout  input  8  write data from CPU.
REQ-009 mem_din  output  8  read data to CPU.
REQ-010 io_buffer_full  output  1  TX FIFO nearly full; the CPU withholds I/O writes while it is high.
REQ-011 tx_data  output  8  byte at the TX FIFO head.
REQ-012 tx_valid  output  1  TX FIFO not empty.
REQ-013 tx_ready  input  1  UART accepts tx_data this cycle.
REQ-014 rx_data  input  8  received UART byte.
REQ-015 rx_valid  input  1  rx_data is valid this cycle; one-cycle strobe.
REQ-016 program_end  output  1  sticky halt flag.
REQ-017 tx_overflow  output  1  sticky; set when a byte is dropped.

Function
REQ-018 Decode: mem_a[17:16]==2'b11 SHALL select I/O; any other value SHALL select RAM index mem_a[RAM_ADDR_W-1:0].
REQ-019 RAM read: mem_din SHALL present the addressed byte exactly one cycle after the address is presented (registered, 1-cycle latency).
REQ-020 RAM write: the byte SHALL be stored at the clock edge where mem_wr=1; a read of the same address on the next cycle SHALL return the new byte.
REQ-021 A write at 0x30000 with nonzero data SHALL push mem_dout into the TX FIFO; data 0x00 SHALL be ignored.
REQ-022 A push while the FIFO holds TX_DEPTH entries SHALL drop the byte and set tx_overflow; FIFO contents and pointers SHALL be unchanged.
REQ-023 A pop SHALL occur when tx_valid && tx_ready; the head advances, and pointers wrap modulo TX_DEPTH.
REQ-024 A push and pop in the same cycle SHALL leave the count unchanged; on a full FIFO, this push is accepted.
REQ-025 io_buffer_full SHALL be registered and equal 1 in the cycle after count >= TX_DEPTH-FULL_MARGIN.
REQ-026 RX: a 2-entry RX buffer SHALL capture rx_data on rx_valid; when it is full, the new byte overwrites the newest entry.
REQ-027 A read at 0x30000 SHALL return the oldest RX byte one cycle later and pop it; if the RX buffer is empty, it SHALL return 0x00.
REQ-028 A 32-bit cycle counter SHALL increment every non-reset cycle and wrap from 0xFFFFFFFF to 0.
REQ-029 A read at 0x30004 SHALL snapshot the counter and return byte 0; reads at 0x30005, 0x30006 and 0x30007 SHALL return bytes 1, 2 and 3 of that snapshot.
REQ-030 A write at 0x30004 SHALL set program_end; after that, TX pushes SHALL be ignored, while draining the TX FIFO continues.
REQ-031 Other I/O offsets SHALL read 0x00, and writes to them SHALL be ignored.
REQ-032 Read and write do not occur in the same cycle; mem_wr alone selects the operation.

Reset
REQ-033 While rst_in=0 at a clock edge: mem_din=0, tx_valid=0, io_buffer_full=0, program_end=0, tx_overflow=0; FIFO and RX pointers clear; counter=0.
REQ-034 RAM contents SHALL NOT be cleared by reset.
REQ-035 Reset asserted mid-transfer SHALL discard all queued TX and RX bytes; the next rst_in=1 cycle behaves as power-on.

Verification
REQ-036 Write 0xA5 to 0x00010, then read 0x00010 -> mem_din=0xA5 on the following cycle.
REQ-037 Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data sequence is 0x41, 0x42 only, and tx_overflow=0.
REQ-038 With tx_ready=0, push 6 bytes -> io_buffer_full=1 the cycle after the 6th; push 3 more -> the 9th is dropped and tx_overflow=1.
REQ-039 Push and pop simultaneously on a full FIFO -> count stays 8; FIFO order is preserved across the pointer wrap.
REQ-040 Release reset; after 100 cycles, read 0x30004..0x30007 -> the 4 bytes form the snapshot value; byte 0 equals the counter at the read cycle.
REQ-041 rx_valid with 0x33, then 0x34; read 0x30000 three times -> 0x33, 0x34, 0x00. Write to 0x30004 -> program_end=1; a later write to 0x30000 is not queued.
